shoukuan: RTL

SHOUKUAN -- requirements
Module: shoukuan

---
 rtl/shoukuan.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/shoukuan.sv
// shoukuan: ticket vending cashier.
// Collects coin/note deposits (values 1/5/10/50), latches the ticket price on
// the first accepted deposit, then either sells a ticket (handing any change to
// the change dispenser) or refunds the whole amount on cancel.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active low
//   in1..in50    coin/note accepted levels; a 0->1 transition is one deposit
//   price        ticket price, 1..255
//   confirm      buy request
//   cancel       abort request (wins over confirm)
//   change_done  change dispenser finished paying out
//   total        money inserted so far
//   money        amount handed to the change dispenser
//   shift        one-cycle load strobe for money
//   ticket       one-cycle ticket-issue pulse
//   reject       one-cycle pulse: deposit refused (would exceed MAXSUM)
//   busy         high while change or refund is being paid out
module shoukuan #(
    parameter int unsigned MAXSUM = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in1,
    input  logic       in5,
    input  logic       in10,
    input  logic       in50,
    input  logic [7:0] price,
    input  logic       confirm,
    input  logic       cancel,
    input  logic       change_done,
    output logic [7:0] total,
    output logic [7:0] money,
    output logic       shift,
    output logic       ticket,
    output logic       reject,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHANGE  = 2'd2,
        REFUND  = 2'd3
    } state_t;

    localparam logic [8:0] MAXSUM9 = 9'(MAXSUM);

    state_t     state, state_d;
    logic [3:0] coin, hist, armed, edge_q;
    logic [7:0] price_q, price_d;
    logic [7:0] total_d, money_d, diff;
    logic       shift_d, ticket_d, reject_d;
    logic [8:0] dep, sum;
    logic       has_dep, fits;

    assign coin = {in50, in10, in5, in1};
    assign busy = (state == CHANGE) || (state == REFUND);

    // Deposit value of the edges registered last cycle, in 9 bits so the
    // overflow test against MAXSUM cannot wrap.
    always_comb begin
        dep = (edge_q[0] ? 9'd1  : 9'd0)
            + (edge_q[1] ? 9'd5  : 9'd0)
            + (edge_q[2] ? 9'd10 : 9'd0)
            + (edge_q[3] ? 9'd50 : 9'd0);
        sum     = {1'b0, total} + dep;
        has_dep = |edge_q;
        fits    = (sum <= MAXSUM9);
        diff    = total - price_q;
    end

    always_comb begin
        state_d  = state;
        total_d  = total;
        money_d  = money;
        price_d  = price_q;
        shift_d  = 1'b0;
        ticket_d = 1'b0;
        reject_d = 1'b0;
        case (state)
            IDLE: begin
                if (has_dep) begin
                    if (fits) begin
                        total_d = sum[7:0];
                        price_d = price;
                        state_d = COLLECT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            COLLECT: begin
                // Any pending deposit is dropped silently when a command is
                // present: commands are resolved against the pre-deposit total.
                if (cancel) begin
                    money_d = total;
                    shift_d = 1'b1;
                    total_d = '0;
                    state_d = REFUND;
                end else if (confirm) begin
                    if (total >= price_q) begin
                        ticket_d = 1'b1;
                        money_d  = diff;
                        total_d  = '0;
                        shift_d  = (diff != 8'd0);
                        state_d  = (diff != 8'd0) ? CHANGE : IDLE;
                    end
                end else if (has_dep) begin
                    if (fits) begin
                        total_d = sum[7:0];
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            CHANGE, REFUND: begin
                if (change_done) begin
                    money_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            hist    <= '0;
            armed   <= '0;
            edge_q  <= '0;
            price_q <= '0;
            total   <= '0;
            money   <= '0;
            shift   <= 1'b0;
            ticket  <= 1'b0;
            reject  <= 1'b0;
        end else begin
            // A line only arms once it has been seen low, so an input held
            // high through reset does not count until it is re-edged.
            hist    <= coin;
            armed   <= armed | ~coin;
            edge_q  <= coin & ~hist & armed;
            state   <= state_d;
            price_q <= price_d;
            total   <= total_d;
            money   <= money_d;
            shift   <= shift_d;
            ticket  <= ticket_d;
            reject  <= reject_d;
        end
    end

endmodule
